// File: rtl/vga_if.sv
// Raster bus between the VGA timing generator and the pixel/colour producers.
// The generator drives the scan position and pin signals, and the producer returns the colour for that position.
interface vga_if;
  logic [11:0] rgb_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        p_tick;
  logic        video_on;
  logic        refr_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] vga_rgb;

  modport master (
    input  rgb_in,
    output x, y, p_tick, video_on, refr_tick, hsync, vsync, vga_rgb
  );

  modport slave (
    output rgb_in,
    input  x, y, p_tick, video_on, refr_tick, hsync, vsync, vga_rgb
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: pixel divider, h/v counters, frame strobe,
// and a registered output stage that keeps colour and sync aligned at the pins.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [9:0]       h_count;
  logic [9:0]       v_count;
  logic             p_tick;
  logic             h_end;
  logic             v_end;
  logic             h_act;
  logic             v_act;
  logic             video_on;
  logic             hsync_q;
  logic             vsync_q;
  logic [11:0]      rgb_q;

  // With CLK_DIV=1 the divider register never leaves 0, so p_tick stays high.
  assign p_tick = (div == DIV_W'(CLK_DIV - 1));
  assign h_end  = (h_count == 10'(H_TOTAL - 1));
  assign v_end  = (v_count == 10'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (p_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (p_tick) begin
      if (h_end) begin
        h_count <= '0;
        v_count <= v_end ? '0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  always_comb begin
    h_act    = (h_count >= 10'(H_DISPLAY + H_FRONT)) &&
               (h_count <= 10'(H_DISPLAY + H_FRONT + H_SYNC - 1));
    v_act    = (v_count >= 10'(V_DISPLAY + V_FRONT)) &&
               (v_count <= 10'(V_DISPLAY + V_FRONT + V_SYNC - 1));
    video_on = (h_count < 10'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));
  end

  // Pins carry the pixel sampled on the previous p_tick: one pixel period behind x/y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      rgb_q   <= 12'h000;
    end else if (p_tick) begin
      hsync_q <= h_act ? SYNC_POL : ~SYNC_POL;
      vsync_q <= v_act ? SYNC_POL : ~SYNC_POL;
      rgb_q   <= video_on ? vga.rgb_in : 12'h000;
    end
  end

  assign vga.x         = h_count;
  assign vga.y         = v_count;
  assign vga.p_tick    = p_tick;
  assign vga.video_on  = video_on;
  assign vga.refr_tick = p_tick && (h_count == 10'd0) && (v_count == 10'(V_DISPLAY + 1));
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.vga_rgb   = rgb_q;
endmodule
